// File: rtl/spi_slave.sv
// spi_slave: SPI responder, far-end counterpart of the SPI master controller.
// It oversamples SCS/SCK/SDI in the clk_in domain and shifts one full-duplex,
// MSB-first word per frame. The sample edge is the trailing edge (the return
// of SCK to SPI_POLARITY). The launch edge is the leading edge.
//
// Ports:
//   clk_in, rst_in   system clock; synchronous active-high reset
//   tx_data_in       reply word for the next frame
//   tx_load_in       one-cycle strobe: tx_data_in -> transmit hold register
//   rx_data_out      last complete received word
//   rx_valid_out     one-cycle pulse when rx_data_out updates
//   frame_err_out    one-cycle pulse at SCS rise if the bit count != TRANSFER_SIZE
//   busy_out         frame in progress (ACTIVE or DONE)
//   spi_scs_in       chip select, active low, asynchronous
//   spi_sck_in       serial clock, asynchronous
//   spi_sdi_in       data from master
//   spi_sdo_out      data to master (1 whenever not ACTIVE)
//   spi_sdo_en_out   SDO pad output enable
module spi_slave #(
    parameter int   TRANSFER_SIZE = 8,
    parameter logic SPI_POLARITY  = 1'b1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [TRANSFER_SIZE-1:0] tx_data_in,
    input  logic                     tx_load_in,
    output logic [TRANSFER_SIZE-1:0] rx_data_out,
    output logic                     rx_valid_out,
    output logic                     frame_err_out,
    output logic                     busy_out,
    input  logic                     spi_scs_in,
    input  logic                     spi_sck_in,
    input  logic                     spi_sdi_in,
    output logic                     spi_sdo_out,
    output logic                     spi_sdo_en_out
);

    localparam int CW = $clog2(TRANSFER_SIZE + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(TRANSFER_SIZE - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(TRANSFER_SIZE);
    localparam logic [CW-1:0] CNT_SAT  = CW'(TRANSFER_SIZE + 1);

    typedef enum logic [1:0] {ST_RESYNC, ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

    state_t state, state_next;

    logic scs_p0, scs_p1, scs_p2;
    logic sck_p0, sck_p1, sck_p2;
    logic sdi_p0, sdi_p1;
    logic sync_primed;

    logic [TRANSFER_SIZE-1:0] tx_hold;
    logic [TRANSFER_SIZE-1:0] tx_shift;
    logic [TRANSFER_SIZE-2:0] rx_shift;
    logic [TRANSFER_SIZE-1:0] rx_word;
    logic [CW-1:0]            bit_cnt;
    logic                     sdo_q;

    logic scs_fall, scs_rise, sck_lead, sck_trail;

    // ---- stage p0/p1: two-flop synchronizers; p2: edge-detect register ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            scs_p0      <= 1'b1;
            scs_p1      <= 1'b1;
            scs_p2      <= 1'b1;
            sck_p0      <= SPI_POLARITY;
            sck_p1      <= SPI_POLARITY;
            sck_p2      <= SPI_POLARITY;
            sdi_p0      <= 1'b1;
            sdi_p1      <= 1'b1;
            sync_primed <= 1'b0;
        end else begin
            scs_p0      <= spi_scs_in;
            scs_p1      <= scs_p0;
            scs_p2      <= scs_p1;
            sck_p0      <= spi_sck_in;
            sck_p1      <= sck_p0;
            sck_p2      <= sck_p1;
            sdi_p0      <= spi_sdi_in;
            sdi_p1      <= sdi_p0;
            sync_primed <= 1'b1;
        end
    end

    // SDI is taken from the same synchronizer depth as the SCK edge decision.
    assign scs_fall  = scs_p2 & ~scs_p1;
    assign scs_rise  = ~scs_p2 & scs_p1;
    assign sck_lead  = (sck_p2 == SPI_POLARITY) && (sck_p1 != SPI_POLARITY);
    assign sck_trail = (sck_p2 != SPI_POLARITY) && (sck_p1 == SPI_POLARITY);
    assign rx_word   = {rx_shift, sdi_p1};

    // ---- FSM next state ----
    always_comb begin
        state_next = state;
        case (state)
            // The synchronizers are forced high by reset, so the first
            // post-reset cycle is discarded (sync_primed). Only then does
            // scs_p0 reflect the pin. This prevents a frame in progress
            // at reset from being joined.
            ST_RESYNC: if (sync_primed && scs_p0 && scs_p1 && scs_p2) state_next = ST_IDLE;
            ST_IDLE:   if (scs_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (scs_rise)
                    state_next = ST_IDLE;
                else if (sck_trail && bit_cnt == CNT_LAST)
                    state_next = ST_DONE;
            end
            ST_DONE:   if (scs_rise) state_next = ST_IDLE;
            default:   state_next = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_RESYNC;
        else        state <= state_next;
    end

    // ---- frame control and registered outputs ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_hold       <= '0;
            rx_data_out   <= '0;
            rx_valid_out  <= 1'b0;
            frame_err_out <= 1'b0;
            bit_cnt       <= '0;
            sdo_q         <= 1'b1;
        end else begin
            rx_valid_out  <= 1'b0;
            frame_err_out <= 1'b0;
            if (tx_load_in) tx_hold <= tx_data_in;
            case (state)
                ST_IDLE: begin
                    sdo_q <= 1'b1;
                    if (scs_fall) bit_cnt <= '0;
                end
                ST_ACTIVE: begin
                    // SCS rise takes priority over a coincident SCK edge.
                    if (scs_rise) begin
                        frame_err_out <= (bit_cnt != CNT_FULL);
                    end else begin
                        if (sck_lead) sdo_q <= tx_shift[TRANSFER_SIZE-1];
                        if (sck_trail) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_LAST) begin
                                rx_data_out  <= rx_word;
                                rx_valid_out <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    sdo_q <= 1'b1;
                    if (scs_rise)
                        frame_err_out <= (bit_cnt != CNT_FULL);
                    else if (sck_trail && bit_cnt != CNT_SAT)
                        bit_cnt <= bit_cnt + 1'b1;
                end
                default: sdo_q <= 1'b1;
            endcase
        end
    end

    // ---- shift registers (data only, no reset) ----
    always_ff @(posedge clk_in) begin
        if (state == ST_IDLE && scs_fall)
            tx_shift <= tx_hold;
        else if (state == ST_ACTIVE && !scs_rise && sck_lead)
            tx_shift <= {tx_shift[TRANSFER_SIZE-2:0], 1'b0};
        if (state == ST_ACTIVE && !scs_rise && sck_trail)
            rx_shift <= rx_word[TRANSFER_SIZE-2:0];
    end

    assign busy_out       = (state == ST_ACTIVE) || (state == ST_DONE);
    assign spi_sdo_en_out = busy_out;
    assign spi_sdo_out    = (state == ST_ACTIVE) ? sdo_q : 1'b1;

endmodule
